// File: rtl/inst_recv.sv
// -----------------------------------------------------------------------------
// inst_recv -- instruction receive buffer between fetch and decode.
//
// Holds one fetch tag (pc + exception info) and its instruction. The
// instruction comes from one of three places: a NOP when the tag carries an
// exception, inst_in when the fetch stage already has it, or an in-order
// instruction-SRAM response (data_ok/rdata). Responses that belong to
// squashed fetches are counted in drop_cnt and thrown away as they arrive.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      fetch-side handshake
//   pc_in, inst_in,
//   inst_valid_in            fetch tag and (optionally) its instruction
//   has_exc_in, ecode_in,
//   esubcode_in              fetch exception tag
//   data_ok, rdata           in-order instruction-SRAM response
//   discard                  one in-flight response is stale
//   flush                    exception / ertn squash
//   out_valid / out_ready    decode-side handshake
//   pc_out, inst_out,
//   has_exc_out, ecode_out,
//   esubcode_out             registered outputs to decode
//   proto_err                sticky: an unexpected data_ok was seen
// -----------------------------------------------------------------------------
module inst_recv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        inst_valid_in,
  input  logic        has_exc_in,
  input  logic [5:0]  ecode_in,
  input  logic [8:0]  esubcode_in,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  input  logic        discard,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        has_exc_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  output logic        proto_err
);

  localparam logic [31:0] NOP = 32'h0340_0000;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_FULL
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        exc_q, exc_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  esub_q, esub_d;
  logic        perr_q, perr_d;

  logic        accept;
  logic        resp_live;   // response that belongs to the live fetch
  logic        consume;
  logic [1:0]  drop_inc;
  logic        drop_dec;
  logic [2:0]  drop_sum;

  // Reset gates in_ready so nothing is accepted during the reset cycle.
  assign in_ready  = !rst && !flush &&
                     ((state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready));
  assign accept    = in_valid && in_ready;
  assign resp_live = data_ok && (drop_q == 2'd0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;
    ecode_d = ecode_q;
    esub_d  = esub_q;
    perr_d  = perr_q;
    consume = 1'b0;

    case (state_q)
      S_EMPTY, S_FULL: begin
        if (accept) begin
          pc_d    = pc_in;
          exc_d   = has_exc_in;
          ecode_d = ecode_in;
          esub_d  = esubcode_in;
          if (has_exc_in) begin
            state_d = S_FULL;
            inst_d  = NOP;
          end else if (inst_valid_in) begin
            state_d = S_FULL;
            inst_d  = inst_in;
          end else if (resp_live) begin
            state_d = S_FULL;
            inst_d  = rdata;
            consume = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else if ((state_q == S_FULL) && out_ready) begin
          state_d = S_EMPTY;
        end
      end
      S_WAIT: begin
        // A live response here always belongs to the held tag, even when a
        // flush squashes it in the same cycle.
        if (resp_live) begin
          state_d = S_FULL;
          inst_d  = rdata;
          consume = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (flush) begin
      state_d = S_EMPTY;
      exc_d   = 1'b0;
    end

    if (resp_live && !consume) perr_d = 1'b1;
  end

  // Drop counter: a flush in WAIT orphans the outstanding response unless it
  // arrives in the very same cycle. Increments of up to 2 saturate at 3; a
  // decrement only happens when the count is nonzero, so no underflow.
  always_comb begin
    drop_inc = {1'b0, discard} +
               {1'b0, (flush && (state_q == S_WAIT) && !resp_live)};
    drop_dec = data_ok && (drop_q != 2'd0);
    drop_sum = {1'b0, drop_q} + {1'b0, drop_inc} - {2'b00, drop_dec};
    drop_d   = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_EMPTY;
      drop_q  <= 2'd0;
      pc_q    <= '0;
      inst_q  <= '0;
      exc_q   <= 1'b0;
      ecode_q <= '0;
      esub_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
      ecode_q <= ecode_d;
      esub_q  <= esub_d;
      perr_q  <= perr_d;
    end
  end

  assign out_valid    = (state_q == S_FULL);
  assign pc_out       = pc_q;
  assign inst_out     = inst_q;
  assign has_exc_out  = exc_q;
  assign ecode_out    = ecode_q;
  assign esubcode_out = esub_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_inst_recv.sv
// -----------------------------------------------------------------------------
// tb_inst_recv -- self-checking bench for inst_recv.
// Expected output beats are pushed to a queue when the accepting stimulus is
// driven and popped by a monitor whenever decode takes a beat.
// -----------------------------------------------------------------------------
module tb_inst_recv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        inst_valid_in;
  logic        has_exc_in;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic        data_ok;
  logic [31:0] rdata;
  logic        discard;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        has_exc_out;
  logic [5:0]  ecode_out;
  logic [8:0]  esubcode_out;
  logic        proto_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  inst_recv dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .inst_valid_in(inst_valid_in),
    .has_exc_in   (has_exc_in),
    .ecode_in     (ecode_in),
    .esubcode_in  (esubcode_in),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .discard      (discard),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
    .has_exc_out  (has_exc_out),
    .ecode_out    (ecode_out),
    .esubcode_out (esubcode_out),
    .proto_err    (proto_err)
  );

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Decode takes a beat on the coming edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {32'h0, pc_out}, 64'hffff_ffff_ffff_ffff);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_pc",   {32'h0, pc_out},   {32'h0, e.pc});
        check("beat_inst", {32'h0, inst_out}, {32'h0, e.inst});
        check("beat_exc",  {48'h0, has_exc_out, ecode_out, esubcode_out},
                           {48'h0, e.exc, e.ecode, e.esub});
      end
    end
  end

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; pc_in = '0; inst_in = '0;
    inst_valid_in = 1'b0; has_exc_in = 1'b0; ecode_in = '0;
    esubcode_in = '0; data_ok = 1'b0; rdata = '0; discard = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  // Finish the current cycle: sample at negedge done by caller, then advance.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    in_valid = 1'b1; pc_in = pc; inst_valid_in = 1'b0; has_exc_in = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                      input logic exc, input logic [5:0] ec, input logic [8:0] es);
    beat_t b;
    b.pc = pc; b.inst = inst; b.exc = exc; b.ecode = ec; b.esub = es;
    sb.push_back(b);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    next();
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_regs", {pc_out, inst_out}, 64'h0);
    check("rst_tag", {47'h0, has_exc_out, ecode_out, esubcode_out, proto_err}, 64'h0);
    next();
    idle();

    // Response arrives two cycles after the accept.
    fetch(32'h1c00_0000);
    push(32'h1c00_0000, 32'h0280_0421, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("idle_in_ready", {63'h0, in_ready}, 64'h1);
    next(); idle();
    @(negedge clk);
    check("wait1_valid", {62'h0, out_valid, in_ready}, 64'h0);
    next();
    data_ok = 1'b1; rdata = 32'h0280_0421;
    @(negedge clk);
    check("wait2_valid", {63'h0, out_valid}, 64'h0);
    next(); idle();
    @(negedge clk);
    check("resp_full", {63'h0, out_valid}, 64'h1);
    next();

    // Backpressure, then reload with no bubble.
    out_ready = 1'b0;
    fetch(32'h1c00_0004); inst_valid_in = 1'b1; inst_in = 32'h0000_0111;
    push(32'h1c00_0004, 32'h0000_0111, 1'b0, 6'h0, 9'h0);
    next();
    fetch(32'h1c00_0008); inst_valid_in = 1'b1; inst_in = 32'h0010_0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'h0, in_ready}, 64'h0);
      check("bp_hold", {31'h0, out_valid, inst_out}, {31'h0, 1'b1, 32'h0000_0111});
      next();
    end
    out_ready = 1'b1;
    push(32'h1c00_0008, 32'h0010_0000, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("reload_in_ready", {63'h0, in_ready}, 64'h1);
    next(); idle();
    @(negedge clk);
    check("no_bubble", {31'h0, out_valid, inst_out}, {31'h0, 1'b1, 32'h0010_0000});
    next();

    // Flush in WAIT orphans its response.
    fetch(32'h1c00_00f0);
    next(); idle();
    flush = 1'b1; fetch(32'h1c00_00f4);
    @(negedge clk);
    check("flush_in_ready", {63'h0, in_ready}, 64'h0);
    next(); idle();
    fetch(32'h1c00_0100);
    push(32'h1c00_0100, 32'h1234_5678, 1'b0, 6'h0, 9'h0);
    next(); idle();
    data_ok = 1'b1; rdata = 32'haaaa_aaaa;
    next();
    rdata = 32'h1234_5678;
    @(negedge clk);
    check("drop_stale", {63'h0, out_valid}, 64'h0);
    next(); idle();
    @(negedge clk);
    check("after_drop", {62'h0, out_valid, proto_err}, 64'h2);
    next();

    // Exception tag: NOP, no response needed.
    fetch(32'h1c00_0200); has_exc_in = 1'b1; ecode_in = 6'h08; esubcode_in = 9'h1ab;
    push(32'h1c00_0200, 32'h0340_0000, 1'b1, 6'h08, 9'h1ab);
    next(); idle();
    @(negedge clk);
    check("exc_full", {63'h0, out_valid}, 64'h1);
    next();

    // discard + flush in WAIT -> two drops; a third response is unexpected.
    fetch(32'h1c00_0300);
    next(); idle();
    discard = 1'b1; flush = 1'b1;
    next(); idle();
    for (int i = 0; i < 2; i++) begin
      data_ok = 1'b1; rdata = 32'h5555_0000 + i;
      next(); idle();
      @(negedge clk);
      check("dropped_no_perr", {62'h0, out_valid, proto_err}, 64'h0);
    end
    data_ok = 1'b1;
    next(); idle();
    @(negedge clk);
    check("extra_perr", {63'h0, proto_err}, 64'h1);
    next();

    // Reset in WAIT with drop_cnt=1 abandons everything.
    fetch(32'h1c00_0400);
    next(); idle();
    discard = 1'b1;
    next(); idle();
    rst = 1'b1;
    next(); idle();
    fetch(32'h1c00_0500); data_ok = 1'b1; rdata = 32'h0bad_f00d;
    push(32'h1c00_0500, 32'h0bad_f00d, 1'b0, 6'h0, 9'h0);
    @(negedge clk);
    check("post_rst_regs", {pc_out, inst_out}, 64'h0);
    check("post_rst_flags", {61'h0, out_valid, has_exc_out, proto_err}, 64'h0);
    next(); idle();
    @(negedge clk);
    check("post_rst_no_drop", {62'h0, out_valid, proto_err}, 64'h2);
    next();

    // Saturation: four discards hold at 3; the fourth response is unexpected.
    for (int i = 0; i < 4; i++) begin
      discard = 1'b1;
      next();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      data_ok = 1'b1;
      next(); idle();
    end
    @(negedge clk);
    check("sat_no_perr", {63'h0, proto_err}, 64'h0);
    next();
    data_ok = 1'b1;
    next(); idle();
    @(negedge clk);
    check("sat_perr", {63'h0, proto_err}, 64'h1);
    next();

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_recv.md
INST_RECV -- requirements
Module: inst_recv

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: in_valid  in  1; in_ready  out  1. Fetch-stage handshake.
REQ-004 SHALL have: pc_in  in  32; inst_in  in  32; inst_valid_in  in  1 (inst_in already holds the instruction).
REQ-005 SHALL have: has_exc_in  in  1; ecode_in  in  6; esubcode_in  in  9. Fetch exception tag.
REQ-006 SHALL have: data_ok  in  1; rdata  in  32. In-order instruction-SRAM responses.
REQ-007 SHALL have: discard  in  1 (one in-flight response is stale); flush  in  1 (exception or ertn squash).
REQ-008 SHALL have: out_valid  out  1; out_ready  in  1. Decode-side handshake.
REQ-009 SHALL have: pc_out  out  32; inst_out  out  32; has_exc_out  out  1; ecode_out  out  6; esubcode_out  out  9. All registered.
REQ-010 SHALL have: proto_err  out  1. Sticky: a data_ok arrived that no consumer expected.

Function
REQ-011 SHALL implement states EMPTY, WAIT (tag held, instruction pending) and FULL (tag and instruction held); out_valid SHALL be 1 exactly in FULL.
REQ-012 SHALL drive in_ready = !flush && (EMPTY || (FULL && out_ready)); accept = in_valid && in_ready.
REQ-013 On accept SHALL latch pc_in, has_exc_in, ecode_in and esubcode_in into the output registers.
REQ-014 On accept with has_exc_in=1: next state FULL; inst_out = 0x03400000 (NOP); no response is consumed.
REQ-015 Else on accept with inst_valid_in=1: next state FULL; inst_out = inst_in.
REQ-016 Else on accept with data_ok=1 and drop_cnt=0: next state FULL; inst_out = rdata; the response is consumed.
REQ-017 Else on accept: next state WAIT.
REQ-018 In WAIT with data_ok=1 and drop_cnt=0: SHALL go to FULL with inst_out = rdata.
REQ-019 In FULL with out_ready=1 and no accept: SHALL go to EMPTY. With a simultaneous accept, SHALL reload per REQ-013..017 with no bubble.
REQ-020 SHALL keep a 2-bit saturating drop_cnt. Each data_ok while drop_cnt>0 is dropped and decrements it. discard=1 increments it. Both in one cycle leave it unchanged. It holds at 3 on increment and at 0 on decrement.
REQ-021 flush=1 SHALL force the next state to EMPTY, clear has_exc_out, and block accept that cycle. If the state is WAIT and no response for it arrives that cycle, drop_cnt SHALL additionally +1 (saturating).
REQ-022 flush and discard in the same cycle SHALL both apply additively to drop_cnt.
REQ-023 A data_ok with drop_cnt=0 in EMPTY or FULL that is not consumed by REQ-016 SHALL be ignored and SHALL set proto_err, which clears only on rst.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-025 While rst=1: state EMPTY, drop_cnt 0, out_valid 0, pc_out 0, inst_out 0, has_exc_out 0, ecode_out 0, esubcode_out 0, proto_err 0; in_ready SHALL read 0 during the reset cycle.
REQ-026 rst SHALL override flush, discard, data_ok and accept; in-flight state is abandoned with no residual drop count.

Verification
REQ-027 Accept pc_in=0x1c000000, inst_valid_in=0, no data_ok; data_ok with rdata=0x02800421 two cycles later -> WAIT for two cycles, then out_valid=1, inst_out=0x02800421, pc_out=0x1c000000.
REQ-028 out_ready=0 while FULL, then in_valid=1 with inst_valid_in=1 and inst_in=0x00100000 -> in_ready=0 and outputs hold. When out_ready rises, next-cycle inst_out=0x00100000 with no empty cycle.
REQ-029 flush in WAIT, then accept with pc_in=0x1c000100, then data_ok rdata=0xAAAAAAAA, then data_ok rdata=0x12345678 -> the first response is dropped; out shows pc_out=0x1c000100, inst_out=0x12345678.
REQ-030 Accept with has_exc_in=1, ecode_in=0x08 -> next cycle FULL, inst_out=0x03400000, has_exc_out=1, ecode_out=0x08, no wait for data_ok.
REQ-031 discard and flush in one cycle while WAIT -> drop_cnt=2; two data_ok pulses dropped; proto_err stays 0. An extra data_ok in EMPTY -> proto_err=1.
REQ-032 Assert rst in WAIT with drop_cnt=1 -> all outputs 0 on the next cycle. A subsequent accept with data_ok in the same cycle -> FULL with rdata, no drop.
